// File: rtl/gray_frame_scheduler.sv
// gray_frame_scheduler: streams one frame from a source to a destination memory, optionally converting RGB444 to gray
module gray_frame_scheduler #(
  parameter int H_PIX  = 320,
  parameter int V_PIX  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  input  logic              wr_ready
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIX * V_PIX - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [1:0] mode_q, count, load;
  logic infl, pop, flush, wp, rp;
  logic [ADDR_W-1:0] infl_addr;
  logic [11:0] sum, px;
  logic [3:0] y;
  logic [ADDR_W+11:0] mem [2];
  logic [ADDR_W+11:0] head;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign flush = abort && (state == RUN || state == DRAIN);
  assign head = mem[rp];
  assign wr_en = count != 2'd0;
  assign wr_addr = wr_en ? head[ADDR_W+11:12] : '0;
  assign wr_data = wr_en ? head[11:0] : '0;
  assign pop = wr_en && wr_ready;
  // entries still held after this cycle's write, plus the read whose data lands next
  assign load = count - {1'b0, pop} + {1'b0, infl};
  assign rd_en = state == RUN && load < 2'd2;
  assign sum = 12'd77 * {8'd0, rd_data[11:8]} + 12'd150 * {8'd0, rd_data[7:4]} + 12'd29 * {8'd0, rd_data[3:0]};
  assign y = 4'(sum >> 8);
  assign px = mode_q == 2'd1 ? {y, y, y} : mode_q == 2'd2 ? {8'h00, y} : rd_data;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (start && !abort) ? RUN : IDLE;
      RUN:     nxt = abort ? IDLE : (rd_en && rd_addr == LAST) ? DRAIN : RUN;
      DRAIN:   nxt = abort ? IDLE : (pop && wr_addr == LAST) ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      mode_q    <= '0;
      rd_addr   <= '0;
      infl      <= 1'b0;
      infl_addr <= '0;
    end else begin
      state     <= nxt;
      mode_q    <= (state == IDLE && start && !abort) ? mode : mode_q;
      rd_addr   <= (nxt != RUN && nxt != DRAIN) ? '0 : (rd_en && rd_addr != LAST) ? rd_addr + 1'b1 : rd_addr;
      infl      <= rd_en && !flush;
      infl_addr <= rd_addr;
    end
  // two-entry skid buffer; head drives the write port directly so it holds while stalled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count  <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count <= flush ? '0 : count + {1'b0, infl} - {1'b0, pop};
      wp    <= flush ? 1'b0 : wp ^ infl;
      rp    <= flush ? 1'b0 : rp ^ pop;
      if (infl && !flush) mem[wp] <= {infl_addr, px};
    end
endmodule

// File: tb/tb_gray_frame_scheduler.sv
// tb_gray_frame_scheduler: randomized frames against a queue scoreboard on a 4x2 frame
module tb_gray_frame_scheduler;
  localparam int H = 4, V = 2, N = H * V, AW = 3;
  typedef struct packed {logic [AW-1:0] a; logic [11:0] d;} wr_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, wr_ready = 1'b1;
  logic [1:0] mode = 2'd0;
  logic busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [11:0] rd_data = 12'h0, wr_data;
  logic [11:0] src [N];
  wr_t exp_q [$];
  wr_t got;
  int compared = 0, mismatched = 0, done_seen = 0;
  logic pend = 1'b0, held = 1'b0;
  logic [AW-1:0] paddr = '0, held_addr = '0;
  logic [11:0] held_data = '0;

  gray_frame_scheduler #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  // source memory: answers a read the cycle after it is issued
  always @(negedge clk) begin
    pend  <= rd_en;
    paddr <= rd_addr;
  end
  always @(posedge clk) rd_data <= pend ? src[paddr] : 12'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_px(input logic [11:0] p, input logic [1:0] m);
    int r = int'(p[11:8]), g = int'(p[7:4]), b = int'(p[3:0]);
    logic [3:0] y = 4'((77 * r + 150 * g + 29 * b) / 256);
    return (m == 2'd1) ? {y, y, y} : (m == 2'd2) ? {8'h00, y} : p;
  endfunction

  always @(negedge clk) begin
    if (held) begin
      check("stall_wr_en", 32'(wr_en), 32'd1);
      check("stall_wr_addr", 32'(wr_addr), 32'(held_addr));
      check("stall_wr_data", 32'(wr_data), 32'(held_data));
    end
    if (wr_en && wr_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: addr %0d data %03h with nothing outstanding", wr_addr, wr_data);
      end else begin
        got = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(got.a));
        check("wr_data", 32'(wr_data), 32'(got.d));
      end
    end
    if (done) done_seen++;
    held      <= wr_en && !wr_ready;
    held_addr <= wr_addr;
    held_data <= wr_data;
  end

  task automatic rand_src();
    for (int i = 0; i < N; i++) src[i] = 12'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pushes the whole frame's expected writes, then leaves us in the first RUN cycle
  task automatic start_frame(input logic [1:0] m);
    wr_t e;
    for (int i = 0; i < N; i++) begin
      e.a = AW'(i);
      e.d = ref_px(src[i], m);
      exp_q.push_back(e);
    end
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 300) begin
      step();
      cyc++;
    end
  endtask

  task automatic finish_frame(input string tag, input int c0, input int lat);
    int cyc;
    wait_done(c0, cyc);
    check({tag, "_done_reached"}, 32'(cyc < 300), 32'd1);
    if (lat > 0) check({tag, "_latency"}, 32'(cyc), 32'(lat));
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    int cyc, d0;
    rand_src();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    step();

    src[0] = 12'hFFF; src[1] = 12'hF00; src[2] = 12'h0F0; src[3] = 12'h00F; src[4] = 12'h000;
    start_frame(2'd1);
    for (int c = 1; c <= N + 4; c++) begin
      check("t1_rd_en", 32'(rd_en), 32'(c <= N));
      if (rd_en) check("t1_rd_addr", 32'(rd_addr), 32'(c - 1));
      check("t1_wr_en", 32'(wr_en), 32'(c >= 3 && c <= N + 2));
      check("t1_done", 32'(done), 32'(c == N + 3));
      check("t1_busy", 32'(busy), 32'(c <= N + 3));
      step();
    end
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    rand_src(); src[0] = 12'hF00;
    start_frame(2'd2);
    finish_frame("mode2", 1, N + 3);
    rand_src(); src[0] = 12'hA5C;
    start_frame(2'd0);
    finish_frame("mode0", 1, N + 3);
    rand_src();
    start_frame(2'd3);
    finish_frame("mode3", 1, N + 3);

    rand_src();
    start_frame(2'($urandom));
    repeat (2) step();
    wr_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j >= 2) check("stall_rd_en", 32'(rd_en), 32'd0);
      step();
    end
    wr_ready = 1'b1;
    finish_frame("stall", 1, 0);

    for (int k = 0; k < 3; k++) begin
      rand_src();
      start_frame(2'($urandom));
      cyc = 1;
      while (!done && cyc < 300) begin
        wr_ready = 1'($urandom);
        step();
        cyc++;
      end
      wr_ready = 1'b1;
      check("rand_done_reached", 32'(cyc < 300), 32'd1);
      step();
      check("rand_drained", 32'(exp_q.size()), 32'd0);
    end

    rand_src();
    start_frame(2'd1);
    cyc = 1;
    while (!(rd_en && rd_addr == 3'd3) && cyc < 20) begin
      step();
      cyc++;
    end
    check("abort_at_px3", 32'(rd_addr), 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(rd_en), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    d0 = done_seen;
    repeat (5) step();
    check("abort_no_done", 32'(done_seen), 32'(d0));
    rand_src();
    start_frame(2'd2);
    check("abort_restart_rd_en", 32'(rd_en), 32'd1);
    check("abort_restart_addr", 32'(rd_addr), 32'd0);
    finish_frame("after_abort", 1, N + 3);

    rand_src();
    start_frame(2'd1);
    for (int c = 0; c < 6; c++) begin
      start = 1'b1;
      mode  = mode + 2'd1;
      step();
    end
    start = 1'b0;
    finish_frame("start_busy", 7, N + 3);

    rand_src();
    start_frame(2'd0);
    wait_done(1, cyc);
    check("done_start_latency", 32'(cyc), 32'(N + 3));
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    step();
    check("done_start_no_read", 32'(rd_en), 32'd0);

    start = 1'b1; abort = 1'b1; mode = 2'd2;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);
    repeat (3) step();
    check("abort_beats_start_idle", 32'(busy), 32'd0);

    rand_src();
    start_frame(2'd1);
    repeat (N) @(posedge clk);
    #1;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_wr_en", 32'(wr_en), 32'd1);
    check("drain_no_read", 32'(rd_en), 32'd0);
    #1 reset_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    rand_src();
    start_frame(2'd1);
    check("post_reset_rd_en", 32'(rd_en), 32'd1);
    check("post_reset_addr", 32'(rd_addr), 32'd0);
    finish_frame("post_reset", 1, N + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end
endmodule
